demux_4to1_capture: RTL and testbench

Sequential 1-to-4 demultiplexer and frame assembler: the receive-side counterpart of the 4-to-1 lane mux. It accepts a stream of WIDTH-bit words on a valid/ready handshake and steers each word into one of four registered output lanes (`a`, `b`, `c`, `d`). Steering is by an explicit `sel` or an internal round-robin slot counter. Once all four lanes hold data, it presents a complete frame to a downstream consumer and holds it until the frame is acknowledged.

---
 rtl/demux_4to1_capture_pkg.sv | 24 ++
 rtl/demux_4to1_capture_if.sv | 32 +++
 rtl/demux_4to1_capture_lane_reg.sv | 25 ++
 rtl/demux_4to1_capture.sv | 101 ++++++++++
 tb/tb_demux_4to1_capture.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_4to1_capture_pkg.sv
// Shared types and constants for the 1-to-4 demux / frame assembler.
// State encoding, lane indices and the lane one-hot helper live here.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [1:0] LANE_A = 2'd0;
    localparam logic [1:0] LANE_B = 2'd1;
    localparam logic [1:0] LANE_C = 2'd2;
    localparam logic [1:0] LANE_D = 2'd3;

    localparam logic [3:0] FULL_MASK = 4'b1111;

    function automatic logic [3:0] laneOneHot(input logic [1:0] idx);
        logic [3:0] mask;
        mask = 4'b0001 << idx;
        return mask;
    endfunction

endpackage

// File: rtl/demux_4to1_capture_if.sv
// Handshake, steering and frame-output bundle of demux_4to1_capture.
// The slave modport is the block itself; the master modport is its environment.
interface demux_4to1_capture_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sel;
    logic             mode;
    logic             clear;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       lane_valid;
    logic             frame_done;
    logic             out_ready;
    logic [1:0]       slot;
    logic             overrun;

    modport slave (
        input  in, in_valid, sel, mode, clear, out_ready,
        output in_ready, a, b, c, d, lane_valid, frame_done, slot, overrun
    );

    modport master (
        output in, in_valid, sel, mode, clear, out_ready,
        input  in_ready, a, b, c, d, lane_valid, frame_done, slot, overrun
    );

endinterface

// File: rtl/demux_4to1_capture_lane_reg.sv
// One lane data register: synchronous clear wins over load, otherwise holds.
// Data is kept across frame consumes; only clear/reset zeroes it.
module lane_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= d;
        end
    end

    assign q = r_data;

endmodule

// File: rtl/demux_4to1_capture.sv
// Receive-side 1-to-4 demux: steers accepted words into four lanes and
// presents a complete frame until the consumer acknowledges it.
module demux_4to1_capture
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    demux_4to1_capture_if.slave bus
);

    state_t           r_state;
    logic [3:0]       r_laneValid;
    logic [1:0]       r_slot;
    logic             r_frameDone;
    logic             r_overrun;

    logic             w_flush;
    logic             w_inReady;
    logic             w_accept;
    logic [1:0]       w_target;
    logic [3:0]       w_targetMask;
    logic [3:0]       w_laneValidNext;
    logic [3:0]       w_load;
    logic [WIDTH-1:0] w_lane [4];

    // Soft clear behaves exactly like reset and outranks every other input.
    assign w_flush         = reset || bus.clear;
    assign w_inReady       = (r_state != FULL);
    assign w_accept        = bus.in_valid && w_inReady;
    assign w_target        = bus.mode ? r_slot : bus.sel;
    assign w_targetMask    = laneOneHot(w_target);
    assign w_laneValidNext = r_laneValid | w_targetMask;
    assign w_load          = w_accept ? w_targetMask : 4'b0000;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        lane_reg #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk  (clk),
            .clear(w_flush),
            .load (w_load[gi]),
            .d    (bus.in),
            .q    (w_lane[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state     <= IDLE;
            r_laneValid <= 4'b0000;
            r_slot      <= 2'd0;
            r_frameDone <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            case (r_state)
                IDLE, FILL: begin
                    if (bus.in_valid) begin
                        r_laneValid <= w_laneValidNext;
                        if (bus.mode) begin
                            r_slot <= r_slot + 2'd1;
                        end
                        if (w_laneValidNext == FULL_MASK) begin
                            r_state     <= FULL;
                            r_frameDone <= 1'b1;
                        end else begin
                            r_state <= FILL;
                        end
                    end
                end
                FULL: begin
                    // Words offered while full are dropped and remembered.
                    if (bus.in_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_laneValid <= 4'b0000;
                        r_slot      <= 2'd0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.a          = w_lane[LANE_A];
    assign bus.b          = w_lane[LANE_B];
    assign bus.c          = w_lane[LANE_C];
    assign bus.d          = w_lane[LANE_D];
    assign bus.lane_valid = r_laneValid;
    assign bus.frame_done = r_frameDone;
    assign bus.slot       = r_slot;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_demux_4to1_capture.sv
// Directed self-checking bench for demux_4to1_capture; each scenario task
// drives its vectors and compares against hand-computed values.
module tb_demux_4to1_capture;

    logic clk;
    logic reset;
    int   checks;
    int   passed;

    demux_4to1_capture_if #(.WIDTH(4)) bus ();

    demux_4to1_capture #(
        .WIDTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic md, input logic [1:0] s,
                         input logic [3:0] data);
        bus.in_valid = valid;
        bus.mode     = md;
        bus.sel      = s;
        bus.in       = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 16'h0000)
            $display("[TB] FAIL reset_lanes actual=%h required=0000", {bus.a, bus.b, bus.c, bus.d});
        else passed++;
        checks++;
        if (bus.lane_valid !== 4'b0000)
            $display("[TB] FAIL reset_lane_valid actual=%b required=0000", bus.lane_valid);
        else passed++;
        checks++;
        if ({bus.frame_done, bus.slot, bus.overrun} !== 4'b0000)
            $display("[TB] FAIL reset_flags actual=%b required=0000", {bus.frame_done, bus.slot, bus.overrun});
        else passed++;
        checks++;
        if (bus.in_ready !== 1'b1)
            $display("[TB] FAIL reset_in_ready actual=%b required=1", bus.in_ready);
        else passed++;
    endtask

    task automatic test_auto_fill();
        drive(1'b1, 1'b1, 2'd0, 4'h3);
        step();
        checks++;
        if ({bus.lane_valid, bus.slot, bus.a} !== {4'b0001, 2'd1, 4'h3})
            $display("[TB] FAIL auto_first actual=%b/%0d/%h required=0001/1/3", bus.lane_valid, bus.slot, bus.a);
        else passed++;
        drive(1'b1, 1'b1, 2'd0, 4'h5);
        step();
        drive(1'b1, 1'b1, 2'd0, 4'h9);
        step();
        checks++;
        if (bus.frame_done !== 1'b0)
            $display("[TB] FAIL auto_early_done actual=%b required=0", bus.frame_done);
        else passed++;
        drive(1'b1, 1'b1, 2'd0, 4'hC);
        step();
        drive(1'b0, 1'b1, 2'd0, 4'h0);
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 16'h359C)
            $display("[TB] FAIL auto_lanes actual=%h required=359c", {bus.a, bus.b, bus.c, bus.d});
        else passed++;
        checks++;
        if ({bus.frame_done, bus.in_ready, bus.slot, bus.lane_valid} !== {1'b1, 1'b0, 2'd0, 4'b1111})
            $display("[TB] FAIL auto_full actual=done%b rdy%b slot%0d lv%b required=done1 rdy0 slot0 lv1111",
                     bus.frame_done, bus.in_ready, bus.slot, bus.lane_valid);
        else passed++;
        step();
        checks++;
        if ({bus.frame_done, bus.in_ready} !== 2'b00)
            $display("[TB] FAIL auto_done_pulse actual=done%b rdy%b required=done0 rdy0", bus.frame_done, bus.in_ready);
        else passed++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.lane_valid, bus.in_ready, bus.a, bus.d} !== {4'b0000, 1'b1, 4'h3, 4'hC})
            $display("[TB] FAIL auto_consume actual=lv%b rdy%b a%h d%h required=lv0000 rdy1 a3 dc",
                     bus.lane_valid, bus.in_ready, bus.a, bus.d);
        else passed++;
    endtask

    task automatic test_explicit_overwrite();
        drive(1'b1, 1'b0, 2'd2, 4'h7);
        step();
        drive(1'b1, 1'b0, 2'd2, 4'hE);
        step();
        checks++;
        if ({bus.c, bus.lane_valid, bus.slot} !== {4'hE, 4'b0100, 2'd0})
            $display("[TB] FAIL expl_overwrite actual=c%h lv%b slot%0d required=ce lv0100 slot0", bus.c, bus.lane_valid, bus.slot);
        else passed++;
        drive(1'b1, 1'b0, 2'd0, 4'h1);
        step();
        drive(1'b1, 1'b0, 2'd1, 4'h2);
        step();
        checks++;
        if ({bus.frame_done, bus.lane_valid} !== {1'b0, 4'b0111})
            $display("[TB] FAIL expl_three actual=done%b lv%b required=done0 lv0111", bus.frame_done, bus.lane_valid);
        else passed++;
        drive(1'b1, 1'b0, 2'd3, 4'h4);
        step();
        drive(1'b0, 1'b0, 2'd0, 4'h0);
        checks++;
        if ({bus.frame_done, bus.lane_valid, bus.a, bus.b, bus.c, bus.d} !== {1'b1, 4'b1111, 16'h12E4})
            $display("[TB] FAIL expl_full actual=done%b lv%b lanes%h required=done1 lv1111 lanes12e4",
                     bus.frame_done, bus.lane_valid, {bus.a, bus.b, bus.c, bus.d});
        else passed++;
    endtask

    task automatic test_overrun();
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b0, 2'd0, 4'h6);
        step();
        drive(1'b0, 1'b0, 2'd0, 4'h0);
        checks++;
        if ({bus.overrun, bus.a, bus.b, bus.c, bus.d} !== {1'b1, 16'h12E4})
            $display("[TB] FAIL overrun_set actual=ovr%b lanes%h required=ovr1 lanes12e4",
                     bus.overrun, {bus.a, bus.b, bus.c, bus.d});
        else passed++;
        checks++;
        if ({bus.lane_valid, bus.in_ready, bus.frame_done} !== {4'b1111, 1'b0, 1'b0})
            $display("[TB] FAIL overrun_state actual=lv%b rdy%b done%b required=lv1111 rdy0 done0",
                     bus.lane_valid, bus.in_ready, bus.frame_done);
        else passed++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.lane_valid, bus.in_ready, bus.overrun, bus.slot} !== {4'b0000, 1'b1, 1'b1, 2'd0})
            $display("[TB] FAIL overrun_sticky actual=lv%b rdy%b ovr%b slot%0d required=lv0000 rdy1 ovr1 slot0",
                     bus.lane_valid, bus.in_ready, bus.overrun, bus.slot);
        else passed++;
    endtask

    task automatic test_clear_priority();
        drive(1'b1, 1'b1, 2'd0, 4'hA);
        step();
        drive(1'b1, 1'b1, 2'd0, 4'hB);
        step();
        checks++;
        if ({bus.lane_valid, bus.slot, bus.a, bus.b} !== {4'b0011, 2'd2, 4'hA, 4'hB})
            $display("[TB] FAIL clear_prefill actual=lv%b slot%0d a%h b%h required=lv0011 slot2 aa bb",
                     bus.lane_valid, bus.slot, bus.a, bus.b);
        else passed++;
        bus.clear = 1'b1;
        drive(1'b1, 1'b1, 2'd0, 4'hF);
        step();
        bus.clear = 1'b0;
        drive(1'b0, 1'b1, 2'd0, 4'h0);
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d} !== 16'h0000)
            $display("[TB] FAIL clear_lanes actual=%h required=0000", {bus.a, bus.b, bus.c, bus.d});
        else passed++;
        checks++;
        if ({bus.lane_valid, bus.slot, bus.overrun, bus.in_ready} !== {4'b0000, 2'd0, 1'b0, 1'b1})
            $display("[TB] FAIL clear_state actual=lv%b slot%0d ovr%b rdy%b required=lv0000 slot0 ovr0 rdy1",
                     bus.lane_valid, bus.slot, bus.overrun, bus.in_ready);
        else passed++;
    endtask

    task automatic test_mode_switch();
        drive(1'b1, 1'b1, 2'd0, 4'h1);
        step();
        drive(1'b1, 1'b1, 2'd0, 4'h2);
        step();
        drive(1'b1, 1'b0, 2'd0, 4'h8);
        step();
        checks++;
        if ({bus.a, bus.slot, bus.lane_valid} !== {4'h8, 2'd2, 4'b0011})
            $display("[TB] FAIL mode_explicit actual=a%h slot%0d lv%b required=a8 slot2 lv0011", bus.a, bus.slot, bus.lane_valid);
        else passed++;
        drive(1'b1, 1'b1, 2'd0, 4'h9);
        step();
        checks++;
        if ({bus.c, bus.slot, bus.lane_valid} !== {4'h9, 2'd3, 4'b0111})
            $display("[TB] FAIL mode_auto actual=c%h slot%0d lv%b required=c9 slot3 lv0111", bus.c, bus.slot, bus.lane_valid);
        else passed++;
        drive(1'b1, 1'b1, 2'd0, 4'h5);
        step();
        drive(1'b0, 1'b1, 2'd0, 4'h0);
        checks++;
        if ({bus.frame_done, bus.a, bus.b, bus.c, bus.d} !== {1'b1, 16'h8295})
            $display("[TB] FAIL mode_frame actual=done%b lanes%h required=done1 lanes8295",
                     bus.frame_done, {bus.a, bus.b, bus.c, bus.d});
        else passed++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int doneCount;
        int notReadyCount;
        int scheduleErrors;
        int word;
        doneCount      = 0;
        notReadyCount  = 0;
        scheduleErrors = 0;
        word           = 0;
        bus.out_ready  = 1'b1;
        // Source offers a word every cycle except the consume cycle of each frame.
        for (int n = 1; n <= 15; n++) begin
            if (n % 5 != 0) begin
                drive(1'b1, 1'b1, 2'd0, 4'(word));
                word++;
            end else begin
                drive(1'b0, 1'b1, 2'd0, 4'h0);
            end
            step();
            if (bus.frame_done === 1'b1) doneCount++;
            if (bus.in_ready === 1'b0) notReadyCount++;
            if (bus.frame_done !== (n % 5 == 4)) scheduleErrors++;
            if (bus.in_ready !== (n % 5 != 4)) scheduleErrors++;
        end
        drive(1'b0, 1'b1, 2'd0, 4'h0);
        bus.out_ready = 1'b0;
        checks++;
        if (doneCount != 3)
            $display("[TB] FAIL b2b_done_count actual=%0d required=3", doneCount);
        else passed++;
        checks++;
        if (notReadyCount != 3)
            $display("[TB] FAIL b2b_not_ready_count actual=%0d required=3", notReadyCount);
        else passed++;
        checks++;
        if (scheduleErrors != 0)
            $display("[TB] FAIL b2b_schedule actual=%0d_errors required=0_errors", scheduleErrors);
        else passed++;
        checks++;
        if ({bus.a, bus.b, bus.c, bus.d, bus.lane_valid, bus.overrun} !== {16'h89AB, 4'b0000, 1'b0})
            $display("[TB] FAIL b2b_final actual=lanes%h lv%b ovr%b required=lanes89ab lv0000 ovr0",
                     {bus.a, bus.b, bus.c, bus.d}, bus.lane_valid, bus.overrun);
        else passed++;
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        reset         = 1'b1;
        bus.in        = 4'h0;
        bus.in_valid  = 1'b0;
        bus.sel       = 2'd0;
        bus.mode      = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_auto_fill();
        test_explicit_overwrite();
        test_overrun();
        test_clear_priority();
        test_mode_switch();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
